// File: rtl/game_score_ctrl.sv
// Game-level controller: turns the running score_pos/score_neg counters into a
// saturating signed net score, runs the countdown timer and IDLE/PLAY/OVER
// state machine, and scans a 4-digit active-low 7-segment display.
module game_score_ctrl #(
  parameter int TICK_DIV     = 25_000_000,
  parameter int GAME_SECONDS = 60,
  parameter int SCAN_BITS    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] score_pos,
  input  logic [5:0] score_neg,
  output logic [1:0] game_state,
  output logic       play,
  output logic [9:0] net_score,
  output logic [6:0] time_left,
  output logic       score_neg_led,
  output logic [3:0] an,
  output logic [6:0] seg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [6:0]        TIME_LOAD = 7'(GAME_SECONDS);

  state_t                state_q, state_d;
  logic                  start_q;
  logic [5:0]            prev_pos_q, prev_neg_q;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [SCAN_BITS-1:0]  scan_q, scan_d;
  logic signed [9:0]     net_q, net_d;
  logic [6:0]            time_q, time_d;
  logic [3:0]            an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  led_q, led_d;
  logic                  play_q, play_d;

  logic                  rise;
  logic [5:0]            dp, dn;
  logic signed [11:0]    sum;
  logic [1:0]            sel;
  logic [6:0]            mag;
  logic [3:0]            digit;

  // Clamp a 12-bit intermediate score into the 10-bit signed range.
  function automatic logic signed [9:0] sat10(input logic signed [11:0] v);
    if (v > 12'sd511)       return 10'sd511;
    else if (v < -12'sd512) return -10'sd512;
    else                    return $signed(v[9:0]);
  endfunction

  // Magnitude of the score limited to two decimal digits; -512 widened first.
  function automatic logic [6:0] mag99(input logic signed [9:0] v);
    logic signed [10:0] w;
    logic [10:0]        a;
    w = $signed({v[9], v});
    a = (w < 0) ? 11'(-w) : 11'(w);
    return (a > 11'd99) ? 7'd99 : a[6:0];
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Next-state logic: deltas, score accumulation, timer, FSM and display digit.
  always_comb begin
    rise   = start & ~start_q;
    dp     = score_pos - prev_pos_q;
    dn     = score_neg - prev_neg_q;
    sum    = $signed({{2{net_q[9]}}, net_q}) + $signed({6'b0, dp}) - $signed({6'b0, dn});

    state_d = state_q;
    net_d   = net_q;
    time_d  = time_q;
    tick_d  = tick_q;

    case (state_q)
      IDLE, OVER: begin
        if (state_q == OVER) tick_d = '0;
        if (rise) begin
          state_d = PLAY;
          net_d   = '0;
          time_d  = TIME_LOAD;
          tick_d  = '0;
        end
      end
      PLAY: begin
        net_d = sat10(sum);
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          time_d = time_q - 7'd1;
          if (time_q == 7'd1) state_d = OVER;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    play_d = (state_d == PLAY);
    led_d  = net_d[9];

    scan_d = scan_q + 1'b1;
    sel    = scan_q[SCAN_BITS-1 -: 2];
    mag    = mag99(net_q);
    case (sel)
      2'd3:    digit = 4'(time_q / 7'd10);
      2'd2:    digit = 4'(time_q % 7'd10);
      2'd1:    digit = 4'(mag / 7'd10);
      default: digit = 4'(mag % 7'd10);
    endcase
    an_d  = ~(4'b0001 << sel);
    seg_d = seg7(digit);
  end

  // State register for the FSM, score, timer, input history and display.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      prev_pos_q <= score_pos;
      prev_neg_q <= score_neg;
      tick_q     <= '0;
      scan_q     <= '0;
      net_q      <= '0;
      time_q     <= TIME_LOAD;
      an_q       <= 4'b1111;
      seg_q      <= 7'h7F;
      led_q      <= 1'b0;
      play_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      prev_pos_q <= score_pos;
      prev_neg_q <= score_neg;
      tick_q     <= tick_d;
      scan_q     <= scan_d;
      net_q      <= net_d;
      time_q     <= time_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      led_q      <= led_d;
      play_q     <= play_d;
    end
  end

  assign game_state    = state_q;
  assign play          = play_q;
  assign net_score     = net_q;
  assign time_left     = time_q;
  assign score_neg_led = led_q;
  assign an            = an_q;
  assign seg           = seg_q;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Bench for game_score_ctrl: behavioural game model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_game_score_ctrl;

  localparam int TD = 10;
  localparam int GS = 3;
  localparam int SB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] score_pos, score_neg;
  logic [1:0] game_state;
  logic       play;
  logic [9:0] net_score;
  logic [6:0] time_left;
  logic       score_neg_led;
  logic [3:0] an;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;

  game_score_ctrl #(.TICK_DIV(TD), .GAME_SECONDS(GS), .SCAN_BITS(SB)) dut (
    .clk(clk), .rst(rst), .start(start), .score_pos(score_pos), .score_neg(score_neg),
    .game_state(game_state), .play(play), .net_score(net_score), .time_left(time_left),
    .score_neg_led(score_neg_led), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the game
  int m_valid = 0;
  int m_state, m_net, m_time, m_tick, m_scan, m_an, m_seg, m_led;
  int m_sp, m_pp, m_pn;
  int seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic model_step();
    int dp, dn, sel, mag, d, nx, rise;
    if (!rst) begin
      m_valid = 1; m_state = 0; m_net = 0; m_time = GS; m_tick = 0; m_scan = 0;
      m_sp = 0; m_pp = int'(score_pos); m_pn = int'(score_neg);
      m_an = 15; m_seg = 7'h7F; m_led = 0;
      return;
    end
    if (!m_valid) return;
    rise = (start && !m_sp) ? 1 : 0;
    m_sp = int'(start);
    dp = (int'(score_pos) - m_pp + 64) % 64;
    dn = (int'(score_neg) - m_pn + 64) % 64;
    m_pp = int'(score_pos);
    m_pn = int'(score_neg);
    // display shows the values held before this edge
    sel = m_scan >> (SB - 2);
    mag = (m_net < 0) ? -m_net : m_net;
    if (mag > 99) mag = 99;
    case (sel)
      3: d = m_time / 10;
      2: d = m_time % 10;
      1: d = mag / 10;
      default: d = mag % 10;
    endcase
    m_an  = 15 - (1 << sel);
    m_seg = seg_tab[d];
    m_scan = (m_scan + 1) % (1 << SB);
    if (m_state == 1) begin
      nx = m_net + dp - dn;
      if (nx > 511) nx = 511;
      if (nx < -512) nx = -512;
      m_net = nx;
      if (m_tick == TD - 1) begin
        m_tick = 0;
        m_time = m_time - 1;
        if (m_time == 0) m_state = 2;
      end else m_tick = m_tick + 1;
    end else begin
      if (m_state == 2) m_tick = 0;
      if (rise) begin
        m_state = 1; m_net = 0; m_time = GS; m_tick = 0;
      end
    end
    m_led = (m_net < 0) ? 1 : 0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (m_valid != 0) begin
      chk("state", int'(game_state), m_state);
      chk("play", int'(play), (m_state == 1) ? 1 : 0);
      chk("net", int'($signed(net_score)), m_net);
      chk("time", int'(time_left), m_time);
      chk("led", int'(score_neg_led), m_led);
      chk("an", int'(an), m_an);
      chk("seg", int'(seg), m_seg);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int hits, prev_time, cnt3, cnt2, cnt1, cnt0;
    rst = 1'b0; start = 1'b0; score_pos = 6'd0; score_neg = 6'd0;

    // 1: reset then idle
    tick(2);
    chk("rst_an", int'(an), 4'b1111);
    chk("rst_seg", int'(seg), 7'h7F);
    chk("rst_time", int'(time_left), 3);
    rst = 1'b1;
    score_pos = 6'd5;
    tick(2);
    chk("idle_state", int'(game_state), 0);
    chk("idle_net", int'($signed(net_score)), 0);

    // 2: start and score
    start = 1'b1;
    tick(1);
    chk("start_state", int'(game_state), 1);
    start = 1'b0;
    score_pos = 6'd8;
    tick(1);
    chk("net_pos3", int'($signed(net_score)), 3);
    score_neg = 6'd1;
    tick(1);
    chk("net_neg1", int'($signed(net_score)), 2);

    // 3: wrap delta and positive saturation
    score_pos = 6'd62;
    tick(1);
    chk("net_56", int'($signed(net_score)), 56);
    score_pos = 6'd1;
    tick(1);
    chk("net_wrap", int'($signed(net_score)), 59);
    for (int i = 0; i < 9; i++) begin
      score_pos = score_pos + 6'd63;
      tick(1);
    end
    chk("sat_pos", int'($signed(net_score)), 511);
    score_pos = score_pos + 6'd63;
    tick(1);
    chk("sat_pos_hold", int'($signed(net_score)), 511);

    // 5b: reset mid-game at time_left 2
    chk("mid_time2", int'(time_left), 2);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    chk("mid_rst_state", int'(game_state), 0);
    chk("mid_rst_net", int'($signed(net_score)), 0);
    chk("mid_rst_time", int'(time_left), 3);

    // 3: negative saturation and display magnitude 99
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      score_neg = score_neg + 6'd63;
      tick(1);
    end
    chk("sat_neg", int'($signed(net_score)), -512);
    chk("sat_neg_led", int'(score_neg_led), 1);
    score_neg = score_neg + 6'd63;
    tick(1);
    chk("sat_neg_hold", int'($signed(net_score)), -512);
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (an == 4'b1110 || an == 4'b1101) begin
        hits++;
        chk("mag99_seg", int'(seg), 7'h10);
      end
    end
    chk("mag99_hits", hits, 8);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;

    // 4: timer with start held high
    start = 1'b1;
    tick(1);
    chk("t_start", int'(game_state), 1);
    for (int k = 1; k <= 40; k++) begin
      if (k == 5)  score_pos = score_pos + 6'd2;
      if (k == 30) score_pos = score_pos + 6'd1;
      if (k == 33) score_pos = score_pos + 6'd5;
      tick(1);
      if (k == 9)  chk("t9_time", int'(time_left), 3);
      if (k == 10) chk("t10_time", int'(time_left), 2);
      if (k == 20) chk("t20_time", int'(time_left), 1);
      if (k == 29) chk("t29_state", int'(game_state), 1);
      if (k == 30) begin
        chk("t30_time", int'(time_left), 0);
        chk("t30_state", int'(game_state), 2);
        chk("t30_net", int'($signed(net_score)), 3);
      end
      if (k == 40) begin
        chk("t40_net", int'($signed(net_score)), 3);
        chk("t40_state", int'(game_state), 2);
      end
    end

    // 5a: restart from OVER
    start = 1'b0;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("restart_state", int'(game_state), 1);
    chk("restart_net", int'($signed(net_score)), 0);
    chk("restart_time", int'(time_left), 3);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;

    // 6: display of net 47
    start = 1'b1;
    tick(1);
    start = 1'b0;
    score_pos = score_pos + 6'd47;
    tick(1);
    chk("disp_net", int'($signed(net_score)), 47);
    chk("disp_time", int'(time_left), 3);
    cnt3 = 0; cnt2 = 0; cnt1 = 0; cnt0 = 0;
    for (int i = 0; i < 16; i++) begin
      prev_time = int'(time_left);
      tick(1);
      chk("an_onehot", $countones(~an), 1);
      case (an)
        4'b0111: begin cnt3++; chk("dig3", int'(seg), 7'h40); end
        4'b1011: begin cnt2++; chk("dig2", int'(seg), (prev_time == 3) ? 7'h30 : 7'h24); end
        4'b1101: begin cnt1++; chk("dig1", int'(seg), 7'h19); end
        4'b1110: begin cnt0++; chk("dig0", int'(seg), 7'h78); end
        default: ;
      endcase
    end
    chk("cnt_dig3", cnt3, 4);
    chk("cnt_dig2", cnt2, 4);
    chk("cnt_dig1", cnt1, 4);
    chk("cnt_dig0", cnt0, 4);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
